// File: rtl/datapath_if.sv
// Control strobes, memory data and observation outputs of the G2 single-bus datapath.
// The sequencer side owns the strobes, and the datapath side owns the register views.
interface datapath_if;
    logic        PCout, zlowout, MDRout, R2out, R3out;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, R1in, R2in, R3in;
    logic        Read, AND, IncPC;
    logic [31:0] MDatain;
    logic [31:0] BusMuxOut;
    logic [31:0] PC_q, IR_q, MAR_q, R1_q, R2_q, R3_q;
    logic [31:0] Zlow_q, Zhigh_q;

    modport master (
        output PCout, zlowout, MDRout, R2out, R3out,
        output PCin, IRin, MARin, MDRin, Yin, Zin, R1in, R2in, R3in,
        output Read, AND, IncPC, MDatain,
        input  BusMuxOut, PC_q, IR_q, MAR_q, R1_q, R2_q, R3_q, Zlow_q, Zhigh_q
    );

    modport slave (
        input  PCout, zlowout, MDRout, R2out, R3out,
        input  PCin, IRin, MARin, MDRin, Yin, Zin, R1in, R2in, R3in,
        input  Read, AND, IncPC, MDatain,
        output BusMuxOut, PC_q, IR_q, MAR_q, R1_q, R2_q, R3_q, Zlow_q, Zhigh_q
    );
endinterface

// File: rtl/datapath.sv
// G2 single-bus 32-bit datapath: PC, IR, MAR, MDR, R1-R3, Y and 64-bit Z on one shared bus.
// The ALU performs bus+1 (IncPC, which has priority), Y&bus (AND), or a bus pass-through.
module datapath (
    input  logic       clock,
    input  logic       reset,
    datapath_if.slave  dp
);
    logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q;
    logic [31:0] r1_q, r2_q, r3_q;
    logic [63:0] z_q;
    logic [31:0] bus_d, mdr_d;
    logic [63:0] alu_d;

    // Out-strobe priority, highest first: MDR, Zlow, PC, R2, R3
    always_comb begin
        bus_d = '0;
        if (dp.MDRout)
            bus_d = mdr_q;
        else if (dp.zlowout)
            bus_d = z_q[31:0];
        else if (dp.PCout)
            bus_d = pc_q;
        else if (dp.R2out)
            bus_d = r2_q;
        else if (dp.R3out)
            bus_d = r3_q;
    end

    always_comb begin
        alu_d = {32'h0, bus_d};
        if (dp.IncPC)
            alu_d = {32'h0, bus_d + 32'd1};
        else if (dp.AND)
            alu_d = {32'h0, y_q & bus_d};
    end

    assign mdr_d = dp.Read ? dp.MDatain : bus_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
            r1_q  <= '0;
            r2_q  <= '0;
            r3_q  <= '0;
        end else begin
            if (dp.PCin)  pc_q  <= bus_d;
            if (dp.IRin)  ir_q  <= bus_d;
            if (dp.MARin) mar_q <= bus_d;
            if (dp.MDRin) mdr_q <= mdr_d;
            if (dp.Yin)   y_q   <= bus_d;
            if (dp.Zin)   z_q   <= alu_d;
            if (dp.R1in)  r1_q  <= bus_d;
            if (dp.R2in)  r2_q  <= bus_d;
            if (dp.R3in)  r3_q  <= bus_d;
        end
    end

    assign dp.BusMuxOut = bus_d;
    assign dp.PC_q      = pc_q;
    assign dp.IR_q      = ir_q;
    assign dp.MAR_q     = mar_q;
    assign dp.R1_q      = r1_q;
    assign dp.R2_q      = r2_q;
    assign dp.R3_q      = r3_q;
    assign dp.Zlow_q    = z_q[31:0];
    assign dp.Zhigh_q   = z_q[63:32];
endmodule

// File: tb/tb_datapath.sv
module tb_datapath;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  datapath_if dif ();
  datapath u_dut (.clock(clock), .reset(reset), .dp(dif.slave));

  typedef enum int {S_BUS, S_PC, S_IR, S_MAR, S_R1, S_R2, S_R3, S_ZLO, S_ZHI} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  event  chk_ev;
  int    checks   = 0;
  int    failures = 0;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      S_BUS:   return dif.BusMuxOut;
      S_PC:    return dif.PC_q;
      S_IR:    return dif.IR_q;
      S_MAR:   return dif.MAR_q;
      S_R1:    return dif.R1_q;
      S_R2:    return dif.R2_q;
      S_R3:    return dif.R3_q;
      S_ZLO:   return dif.Zlow_q;
      default: return dif.Zhigh_q;
    endcase
  endfunction

  initial begin
    item_t it;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() != 0) begin
        it  = sb.pop_front();
        act = observe(it.sel);
        checks++;
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input sel_e sel, input logic [31:0] exp);
    item_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  task automatic check_now();
    -> chk_ev;
    #1;
  endtask

  task automatic clr();
    dif.PCout = 0; dif.zlowout = 0; dif.MDRout = 0; dif.R2out = 0; dif.R3out = 0;
    dif.PCin = 0; dif.IRin = 0; dif.MARin = 0; dif.MDRin = 0; dif.Yin = 0;
    dif.Zin = 0; dif.R1in = 0; dif.R2in = 0; dif.R3in = 0;
    dif.Read = 0; dif.AND = 0; dif.IncPC = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    dif.MDatain = 32'h0;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_val("rst_pc", S_PC, 32'h0);
    expect_val("rst_ir", S_IR, 32'h0);
    expect_val("rst_mar", S_MAR, 32'h0);
    expect_val("rst_r1", S_R1, 32'h0);
    expect_val("rst_r2", S_R2, 32'h0);
    expect_val("rst_r3", S_R3, 32'h0);
    expect_val("rst_zlo", S_ZLO, 32'h0);
    expect_val("rst_zhi", S_ZHI, 32'h0);
    expect_val("rst_bus_idle", S_BUS, 32'h0);
    check_now();

    clr(); dif.MDatain = 32'h12; dif.Read = 1; dif.MDRin = 1; tick();
    clr(); dif.MDRout = 1; dif.R2in = 1;
    expect_val("pre_bus_12", S_BUS, 32'h12); check_now();
    tick(); expect_val("pre_r2", S_R2, 32'h12); check_now();

    clr(); dif.MDatain = 32'h14; dif.Read = 1; dif.MDRin = 1; tick();
    clr(); dif.MDRout = 1; dif.R3in = 1; tick();
    expect_val("pre_r3", S_R3, 32'h14); check_now();

    clr(); dif.MDatain = 32'h18; dif.Read = 1; dif.MDRin = 1; tick();
    clr(); dif.MDRout = 1; dif.R1in = 1; tick();
    expect_val("pre_r1", S_R1, 32'h18); check_now();

    clr(); dif.PCout = 1; dif.MARin = 1; dif.IncPC = 1; dif.Zin = 1;
    expect_val("t0_bus", S_BUS, 32'h0); check_now();
    tick();
    expect_val("t0_mar", S_MAR, 32'h0);
    expect_val("t0_zlo", S_ZLO, 32'h1); check_now();

    clr(); dif.zlowout = 1; dif.PCin = 1; dif.Read = 1; dif.MDRin = 1;
    dif.MDatain = 32'h28918000;
    expect_val("t1_bus", S_BUS, 32'h1); check_now();
    tick(); expect_val("t1_pc", S_PC, 32'h1); check_now();

    clr(); dif.MDRout = 1; dif.IRin = 1;
    expect_val("t2_bus", S_BUS, 32'h28918000); check_now();
    tick(); expect_val("t2_ir", S_IR, 32'h28918000); check_now();

    clr(); dif.R2out = 1; dif.Yin = 1;
    expect_val("t3_bus", S_BUS, 32'h12); check_now();
    tick();
    clr(); dif.R3out = 1; dif.AND = 1; dif.Zin = 1; tick();
    expect_val("t4_zlo_and", S_ZLO, 32'h10);
    expect_val("t4_zhi", S_ZHI, 32'h0); check_now();
    clr(); dif.zlowout = 1; dif.R1in = 1;
    expect_val("t5_bus", S_BUS, 32'h10); check_now();
    tick();
    expect_val("t5_r1", S_R1, 32'h10);
    expect_val("t5_pc_hold", S_PC, 32'h1); check_now();

    clr(); dif.MDatain = 32'hFFFFFFFF; dif.Read = 1; dif.MDRin = 1; tick();
    clr(); dif.MDRout = 1; dif.PCin = 1; tick();
    expect_val("pc_max", S_PC, 32'hFFFFFFFF); check_now();
    clr(); dif.PCout = 1; dif.IncPC = 1; dif.Zin = 1; tick();
    expect_val("wrap_zlo", S_ZLO, 32'h0);
    expect_val("wrap_zhi", S_ZHI, 32'h0); check_now();

    clr(); dif.MDRout = 1; dif.R2out = 1;
    expect_val("prio_mdr_r2", S_BUS, 32'hFFFFFFFF); check_now();
    clr(); dif.zlowout = 1; dif.PCout = 1;
    expect_val("prio_zlo_pc", S_BUS, 32'h0); check_now();
    clr(); dif.PCout = 1; dif.R3out = 1;
    expect_val("prio_pc_r3", S_BUS, 32'hFFFFFFFF); check_now();

    clr(); dif.R2out = 1; dif.AND = 1; dif.IncPC = 1; dif.Zin = 1; tick();
    expect_val("inc_over_and", S_ZLO, 32'h13); check_now();

    clr(); dif.R2out = 1; dif.R2in = 1; dif.Zin = 1; tick();
    expect_val("self_r2", S_R2, 32'h12);
    expect_val("pass_zlo", S_ZLO, 32'h12); check_now();

    clr(); dif.MDRout = 1; dif.R2in = 1; dif.R3in = 1; tick();
    expect_val("multi_r2", S_R2, 32'hFFFFFFFF);
    expect_val("multi_r3", S_R3, 32'hFFFFFFFF); check_now();

    clr(); dif.R3out = 1; dif.AND = 1; dif.Zin = 1; reset = 1'b1; tick();
    reset = 1'b0;
    expect_val("mrst_zlo", S_ZLO, 32'h0);
    expect_val("mrst_pc", S_PC, 32'h0);
    expect_val("mrst_r1", S_R1, 32'h0);
    expect_val("mrst_r2", S_R2, 32'h0);
    expect_val("mrst_r3", S_R3, 32'h0); check_now();
    clr(); dif.zlowout = 1; dif.R1in = 1;
    expect_val("mrst_t5_bus", S_BUS, 32'h0); check_now();
    tick(); expect_val("mrst_t5_r1", S_R1, 32'h0); check_now();

    clr();
    #1;
    checks++;
    if (dif.R1_q !== 32'h0) begin
      failures++;
      $display("FAIL final_r1: got 0x%08h expected 0x%08h", dif.R1_q, 32'h0);
    end
    checks++;
    if (dif.R2_q !== 32'h0) begin
      failures++;
      $display("FAIL final_r2: got 0x%08h expected 0x%08h", dif.R2_q, 32'h0);
    end
    checks++;
    if (dif.Zhigh_q !== 32'h0) begin
      failures++;
      $display("FAIL final_zhi: got 0x%08h expected 0x%08h", dif.Zhigh_q, 32'h0);
    end
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
